// File: rtl/memory_stage_pkg.sv
// memory_stage shared definitions: access sizes, FSM encodings and
// the store-side lane steering helpers.
package memory_stage_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam logic [1:0] MS_IDLE = 2'b00;
    localparam logic [1:0] MS_REQ  = 2'b01;
    localparam logic [1:0] MS_WAIT = 2'b10;
    localparam logic [1:0] MS_DONE = 2'b11;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic m;
        m = 1'b0;
        unique case (1'b1)
            (size == MEM_SIZE_B): m = 1'b0;
            (size == MEM_SIZE_H): m = a[0];
            default:              m = |a;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] wstrb_of(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] s;
        s = 4'b0000;
        unique case (1'b1)
            (size == MEM_SIZE_B): s = 4'b0001 << a;
            (size == MEM_SIZE_H): s = 4'b0011 << {a[1], 1'b0};
            default:              s = 4'b1111;
        endcase
        return s;
    endfunction

    // Replicate right-aligned store data across every lane it may land in
    function automatic logic [31:0] wdata_of(
        input logic [1:0]  size,
        input logic [31:0] b
    );
        logic [31:0] d;
        d = '0;
        unique case (1'b1)
            (size == MEM_SIZE_B): d = {4{b[7:0]}};
            (size == MEM_SIZE_H): d = {2{b[15:0]}};
            default:              d = b;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/gnt/rvalid port bundle; master is the M stage,
// slave is the memory or bus fabric.
interface memory_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [3:0]      dmem_wstrb_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_gnt_i;
    logic            dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o,
        output dmem_wstrb_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o,
        input  dmem_wstrb_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/memory_stage_mem_load_fmt.sv
// Load data formatter: picks the addressed lane out of a word-aligned
// read and sign- or zero-extends it.
module mem_load_fmt
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] val_o
);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh    = rdata_i >> {addr_i, 3'b000};
        b     = sh[7:0];
        h     = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        val_o = rdata_i;
        unique case (1'b1)
            (size_i == MEM_SIZE_B):
                val_o = {{24{~unsigned_i & b[7]}}, b};
            (size_i == MEM_SIZE_H):
                val_o = {{16{~unsigned_i & h[15]}}, h};
            default:
                val_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// M-stage data-memory access unit: drives the dmem port, formats loads,
// flags misalignment and bus timeout, and stalls until the access is done.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              ED_mem_read_i,
    input  logic              ED_mem_write_i,
    input  logic [1:0]        ED_mem_size_i,
    input  logic              ED_mem_unsigned_i,
    input  logic [XLEN-1:0]   ED_valE_i,
    input  logic [XLEN-1:0]   ED_valB_i,
    input  logic              M_advance_i,
    memory_stage_if.master    dmem,
    output logic [XLEN-1:0]   M_valM_o,
    output logic              M_stall_o,
    output logic              M_misalign_o,
    output logic              M_bus_err_o
);
    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hold_val_q, hold_val_d;
    logic            hold_mis_q, hold_mis_d;
    logic            hold_err_q, hold_err_d;

    logic            op, mis, timeout, req, done;
    logic [XLEN-1:0] fmt_val, val;
    logic            mis_flag, err_flag;

    assign op      = ED_mem_read_i | ED_mem_write_i;
    assign mis     = is_misaligned(ED_mem_size_i, ED_valE_i[1:0]);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    mem_load_fmt u_fmt (
        .rdata_i    (dmem.dmem_rdata_i),
        .addr_i     (ED_valE_i[1:0]),
        .size_i     (ED_mem_size_i),
        .unsigned_i (ED_mem_unsigned_i),
        .val_o      (fmt_val)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        hold_val_d = hold_val_q;
        hold_mis_d = hold_mis_q;
        hold_err_d = hold_err_q;
        req        = 1'b0;
        done       = 1'b0;
        val        = '0;
        mis_flag   = 1'b0;
        err_flag   = 1'b0;
        unique case (1'b1)
            (state_q == MS_IDLE): begin
                if (op && mis) begin
                    done     = 1'b1;
                    mis_flag = 1'b1;
                end else if (op) begin
                    req = 1'b1;
                    if (!dmem.dmem_gnt_i) state_d = MS_REQ;
                    else if (ED_mem_write_i) done = 1'b1;
                    else state_d = MS_WAIT;
                end
            end
            (state_q == MS_REQ): begin
                if (timeout) begin
                    done     = 1'b1;
                    err_flag = 1'b1;
                end else begin
                    req   = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (dmem.dmem_gnt_i && ED_mem_write_i) done = 1'b1;
                    else if (dmem.dmem_gnt_i) state_d = MS_WAIT;
                end
            end
            (state_q == MS_WAIT): begin
                if (dmem.dmem_rvalid_i) begin
                    done = 1'b1;
                    val  = fmt_val;
                end else if (timeout) begin
                    done     = 1'b1;
                    err_flag = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                val      = hold_val_q;
                mis_flag = hold_mis_q;
                err_flag = hold_err_q;
                if (M_advance_i) state_d = MS_IDLE;
            end
        endcase
        // An unconsumed result parks in DONE until the M/W register takes it
        if (done) begin
            cnt_d = '0;
            if (M_advance_i) begin
                state_d = MS_IDLE;
            end else begin
                state_d    = MS_DONE;
                hold_val_d = val;
                hold_mis_d = mis_flag;
                hold_err_d = err_flag;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= MS_IDLE;
            cnt_q      <= '0;
            hold_val_q <= '0;
            hold_mis_q <= 1'b0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_val_q <= hold_val_d;
            hold_mis_q <= hold_mis_d;
            hold_err_q <= hold_err_d;
        end
    end

    assign dmem.dmem_req_o   = req;
    assign dmem.dmem_we_o    = req & ED_mem_write_i;
    assign dmem.dmem_addr_o  = req ? {ED_valE_i[XLEN-1:2], 2'b00} : '0;
    assign dmem.dmem_wstrb_o = req ? wstrb_of(ED_mem_size_i, ED_valE_i[1:0]) : 4'b0000;
    assign dmem.dmem_wdata_o = req ? wdata_of(ED_mem_size_i, ED_valB_i) : '0;

    assign M_valM_o     = val;
    assign M_misalign_o = mis_flag;
    assign M_bus_err_o  = err_flag;
    assign M_stall_o    = op & ~done & (state_q != MS_DONE);
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- M-stage data-memory access unit.
- Sits between the E/M pipeline register (ED_* signals) and the M/W register, which captures M_valM_o.
- Drives a req/gnt/rvalid data-memory port with byte-lane steering, formats load data, and detects misalignment and bus timeout.
- Stalls the pipeline until the access completes, and holds the result until the M/W register advances.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT_CYC, 64, cycles spent in REQ+WAIT before an access is aborted with a bus error.
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- ED_mem_read_i  in  1  load in M stage
- ED_mem_write_i  in  1  store in M stage; never set together with read
- ED_mem_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- ED_mem_unsigned_i  in  1  zero-extend load when set
- ED_valE_i  in  XLEN  effective address
- ED_valB_i  in  XLEN  store data, right-aligned
- M_advance_i  in  1  M/W register captures this cycle (~M_stall & ~M_bubble of that register)
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  XLEN  read data, word-aligned
- dmem_req_o  out  1  request
- dmem_we_o  out  1  write enable
- dmem_addr_o  out  XLEN  {ED_valE_i[XLEN-1:2],2'b00}
- dmem_wstrb_o  out  4  byte strobes
- dmem_wdata_o  out  XLEN  lane-replicated store data
- M_valM_o  out  XLEN  formatted load result; 0 for non-loads and errors
- M_stall_o  out  1  access not complete; hold F/D/E/M
- M_misalign_o  out  1  misaligned access, valid while the instruction is in M
- M_bus_err_o  out  1  timeout abort, valid while the instruction is in M

Behaviour:
- Definitions:
  - op = read|write.
  - mis = (half & addr[0]) | (word & addr[1:0]!=0).
- States: IDLE, REQ, WAIT, DONE. Reset (rst_n=0 at a clk edge) applies:
  - state=IDLE, counter=0, hold buffer=0, error flags=0.
  - All outputs then read 0.
  - A reset mid-access abandons the access; a late gnt/rvalid is ignored in IDLE unless req was raised.
- IDLE:
  - !op: all outputs 0, no stall.
  - op & mis: no request; M_misalign_o=1 and M_valM_o=0, combinationally. Completion is immediate (no stall). If !M_advance_i, go to DONE with the flag held.
  - op & !mis: dmem_req_o=1 combinationally, so best-case latency is 0 wait cycles for a write.
    - gnt & write: complete.
    - gnt & read: go to WAIT.
    - no gnt: go to REQ.
- REQ: dmem_req_o=1; address, wstrb and wdata are held stable (ED_* are frozen by the stall).
  - gnt & write: complete.
  - gnt & read: go to WAIT.
- WAIT: dmem_req_o=0. rvalid completes the access, with M_valM_o formatted from dmem_rdata_i in the same cycle.
- Completion cycle:
  - M_stall_o=0.
  - If M_advance_i: go to IDLE.
  - Else: go to DONE, latching M_valM_o and the error flags into the hold buffer.
- DONE: outputs come from the hold buffer, M_stall_o=0, no request. Go to IDLE on M_advance_i.
- M_stall_o = op & !complete_this_cycle & state!=DONE.
- Timeout:
  - The counter increments each cycle in REQ/WAIT and clears on leaving them.
  - At counter == TIMEOUT_CYC-1 without completion, the access completes with M_bus_err_o=1 and M_valM_o=0.
  - dmem_req_o drops that cycle.
- Store strobes:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{b[7:0]}}
  - half: {2{b[15:0]}}
  - word: b
- Load format: select the lane by addr[1:0] (half uses addr[1]), then sign-extend from bit 7/15 unless unsigned.
- Simultaneous gnt & rvalid in REQ for a read: the rvalid is ignored; the response is expected from the next cycle onward.

Decomposition:
- define.v additions:
  - `MEM_SIZE_B/H/W
  - state encodings `MS_IDLE/`MS_REQ/`MS_WAIT/`MS_DONE (2 bits)
- Sub-module: mem_load_fmt, combinational (rdata, addr[1:0], size, unsigned -> valM). It is reused by any future cache refill path.

Test Plan:
- Word load at 0x100, gnt same cycle, rvalid 2 cycles later with 0xDEADBEEF, M_advance_i high -> M_stall_o high for 2 cycles, then M_valM_o=0xDEADBEEF with stall low.
- Signed byte load at 0x103, rdata=0x80FF1234 -> M_valM_o=0xFFFFFF80. The same access unsigned -> 0x00000080.
- Half store at 0x202 of ED_valB_i=0x0000ABCD -> dmem_wstrb_o=4'b1100, dmem_wdata_o=0xABCDABCD, dmem_addr_o=0x200. gnt delayed 3 cycles -> stall for exactly 3 cycles.
- Word load at 0x101 -> no dmem_req_o, M_misalign_o=1, M_valM_o=0, M_stall_o=0.
- Load completes while M_advance_i=0 for 4 cycles -> DONE holds M_valM_o stable. A second rvalid pulse in DONE does not change it. IDLE on advance.
- gnt never asserted, TIMEOUT_CYC=8 -> stall for 8 cycles, then M_bus_err_o=1 and req low. Separately, rst_n low while in WAIT -> next cycle IDLE, all outputs 0.
